// File: rtl/pipe_scroller.sv
// pipe_scroller: obstacle generator for the Flappy Bird game.
// Owns NUM_PIPES pipes. Each tick the pipes scroll left by `speed` pixels.
// A pipe that would scroll past column 0 respawns at the right edge with a
// pseudorandom gap height. The block also counts bird passes and raises the
// scroll speed every PASSES_PER_LEVEL passes.

// One pipe: its position/gap registers plus wrap and pass detection.
module pipe_lane #(
   parameter int IDX       = 0,
   parameter int X_W       = 11,
   parameter int SCREEN_W  = 640,
   parameter int SPACING   = 320,
   parameter int GAP_BASE  = 200,
   parameter int RAND_BITS = 8
) (
   input  logic           game_clk,
   input  logic           init,
   input  logic           enable,
   input  logic [9:0]     random,
   input  logic [X_W-1:0] bird_x,
   input  logic [2:0]     speed,
   output logic [X_W-1:0] x,
   output logic [X_W-1:0] y,
   output logic           hit
);

   // Initial column wraps modulo 2^X_W, so any SPACING elaborates cleanly.
   localparam logic [X_W-1:0] X_INIT    = X_W'((IDX + 1) * SPACING - 1);
   localparam logic [X_W-1:0] X_RESPAWN = X_W'(SCREEN_W - 1);
   localparam logic [31:0]    RMASK     = 32'((1 << RAND_BITS) - 1);

   logic [9:0]     rot;
   logic [X_W-1:0] gap;
   logic [X_W-1:0] spd;
   logic [X_W-1:0] step;
   logic           wrap;

   // Per-pipe rotation of the LFSR gives each respawning pipe its own gap,
   // even when several pipes respawn in the same tick. Pass detection uses
   // the pre-update column so a fast pipe cannot jump over the bird.
   always_comb begin
      rot  = 10'((32'(random) << IDX) | (32'(random) >> (10 - IDX)));
      gap  = X_W'(GAP_BASE + (32'(rot) & RMASK));
      spd  = X_W'(speed);
      wrap = x < spd;
      step = x - spd;
      hit  = (x > bird_x) && (wrap || step <= bird_x);
   end

   // Position and gap registers: init, wrap to the right edge, or scroll.
   always_ff @(posedge game_clk) begin
      if (init) begin
         x <= X_INIT;
         y <= gap;
      end else if (enable) begin
         if (wrap) begin
            x <= X_RESPAWN;
            y <= gap;
         end else begin
            x <= step;
         end
      end
   end

endmodule

module pipe_scroller #(
   parameter int NUM_PIPES        = 2,
   parameter int X_W              = 11,
   parameter int SCREEN_W         = 640,
   parameter int SPACING          = 320,
   parameter int GAP_BASE         = 200,
   parameter int RAND_BITS        = 8,
   parameter int PASSES_PER_LEVEL = 5,
   parameter int MAX_SPEED        = 4
) (
   input  logic                       game_clk,
   input  logic                       reset,
   input  logic                       restart,
   input  logic                       enable,
   input  logic [9:0]                 random,
   input  logic [X_W-1:0]             bird_x,
   output logic [NUM_PIPES*X_W-1:0]   pipe_x,
   output logic [NUM_PIPES*X_W-1:0]   pipe_y,
   output logic                       pass,
   output logic [7:0]                 pass_count,
   output logic [2:0]                 speed
);

   localparam logic [7:0] PPL8 = 8'(PASSES_PER_LEVEL);
   localparam logic [2:0] MAX3 = 3'(MAX_SPEED);

   // Parameter sanity: the gap range must fit in a coordinate, and the
   // counters/speed field must be able to hold the configured values.
   if (GAP_BASE + (2 ** RAND_BITS) - 1 >= (2 ** X_W)) begin : g_chk_gap
      $error("pipe_scroller: GAP_BASE + 2^RAND_BITS - 1 does not fit in X_W");
   end
   if (NUM_PIPES < 1 || NUM_PIPES > 8) begin : g_chk_pipes
      $error("pipe_scroller: NUM_PIPES must be 1..8");
   end
   if (RAND_BITS < 1 || RAND_BITS > 10) begin : g_chk_rand
      $error("pipe_scroller: RAND_BITS must be 1..10");
   end
   if (MAX_SPEED < 1 || MAX_SPEED > 7) begin : g_chk_speed
      $error("pipe_scroller: MAX_SPEED must be 1..7");
   end
   if (PASSES_PER_LEVEL < 1 || PASSES_PER_LEVEL > 255) begin : g_chk_ppl
      $error("pipe_scroller: PASSES_PER_LEVEL must be 1..255");
   end
   if (X_W < 4) begin : g_chk_xw
      $error("pipe_scroller: X_W must be at least 4");
   end

   logic                 init;
   logic [NUM_PIPES-1:0] hits;
   logic [3:0]           pop;
   logic [8:0]           sum;
   logic [7:0]           cnt_next;
   logic                 level_up;
   logic [2:0]           spd_next;

   assign init = reset | restart;

   for (genvar g = 0; g < NUM_PIPES; g++) begin : g_lane
      pipe_lane #(
         .IDX       (g),
         .X_W       (X_W),
         .SCREEN_W  (SCREEN_W),
         .SPACING   (SPACING),
         .GAP_BASE  (GAP_BASE),
         .RAND_BITS (RAND_BITS)
      ) u_lane (
         .game_clk (game_clk),
         .init     (init),
         .enable   (enable),
         .random   (random),
         .bird_x   (bird_x),
         .speed    (speed),
         .x        (pipe_x[g*X_W +: X_W]),
         .y        (pipe_y[g*X_W +: X_W]),
         .hit      (hits[g])
      );
   end

   // Count this tick's passes, saturate the total, and detect a level
   // boundary crossing (at most one speed step per tick).
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_PIPES; i++) pop = pop + 4'(hits[i]);
      sum      = 9'(pass_count) + 9'(pop);
      cnt_next = sum[8] ? 8'hFF : sum[7:0];
      level_up = (pass_count / PPL8) != (cnt_next / PPL8);
      spd_next = (level_up && speed < MAX3) ? speed + 3'd1 : speed;
   end

   // Shared state: pass pulse, pass counter and current speed.
   always_ff @(posedge game_clk) begin
      if (init) begin
         pass       <= 1'b0;
         pass_count <= 8'd0;
         speed      <= 3'd1;
      end else if (enable) begin
         pass       <= |hits;
         pass_count <= cnt_next;
         speed      <= spd_next;
      end else begin
         pass       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipe_scroller.sv
// Bench for pipe_scroller: directed scenarios plus randomized stimulus,
// checked every tick against a behavioural model of the scrolling rules.
module tb_pipe_scroller;

   localparam int NP  = 2;
   localparam int XW  = 11;
   localparam int SW  = 640;
   localparam int SP  = 320;
   localparam int GB  = 200;
   localparam int RB  = 8;
   localparam int PPL = 5;
   localparam int MS  = 4;

   logic              game_clk = 1'b0;
   logic              reset, restart, enable;
   logic [9:0]        random;
   logic [XW-1:0]     bird_x;
   logic [NP*XW-1:0]  pipe_x, pipe_y;
   logic              pass;
   logic [7:0]        pass_count;
   logic [2:0]        speed;

   // Second instance: SPACING=2048 makes both pipes start at the same
   // column (modulo 2^11) so they reach x=0 and respawn in the same tick.
   logic              restart2;
   logic [XW-1:0]     bird_x2;
   logic [NP*XW-1:0]  px2, py2;
   logic              pass2;
   logic [7:0]        pc2;
   logic [2:0]        spd2;

   pipe_scroller #(.NUM_PIPES(NP), .X_W(XW), .SCREEN_W(SW), .SPACING(SP),
      .GAP_BASE(GB), .RAND_BITS(RB), .PASSES_PER_LEVEL(PPL), .MAX_SPEED(MS)) dut (
      .game_clk(game_clk), .reset(reset), .restart(restart), .enable(enable),
      .random(random), .bird_x(bird_x), .pipe_x(pipe_x), .pipe_y(pipe_y),
      .pass(pass), .pass_count(pass_count), .speed(speed));

   pipe_scroller #(.NUM_PIPES(NP), .X_W(XW), .SCREEN_W(SW), .SPACING(2048),
      .GAP_BASE(GB), .RAND_BITS(RB), .PASSES_PER_LEVEL(PPL), .MAX_SPEED(MS)) dut2 (
      .game_clk(game_clk), .reset(reset), .restart(restart2), .enable(1'b1),
      .random(random), .bird_x(bird_x2), .pipe_x(px2), .pipe_y(py2),
      .pass(pass2), .pass_count(pc2), .speed(spd2));

   always #5 game_clk = ~game_clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int mx[NP];
   int my[NP];
   int mspd, mcnt;
   bit mpass;

   function automatic int rotv(int r, int i);
      int v;
      v = r & 'h3FF;
      return ((v << i) | (v >> (10 - i))) & 'h3FF;
   endfunction

   function automatic int gapv(int r, int i);
      return GB + (rotv(r, i) & ((1 << RB) - 1));
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int lx(int i);
      return int'(pipe_x[i*XW +: XW]);
   endfunction

   function automatic int ly(int i);
      return int'(pipe_y[i*XW +: XW]);
   endfunction

   // Advance the model by one game tick using the inputs seen at the edge.
   task automatic model_step();
      int pc, b, nc;
      bit w, p;
      if (reset || restart) begin
         for (int i = 0; i < NP; i++) begin
            mx[i] = ((i + 1) * SP - 1) % (1 << XW);
            my[i] = gapv(int'(random), i);
         end
         mspd = 1; mcnt = 0; mpass = 0;
      end else if (enable) begin
         pc = 0;
         b  = int'(bird_x);
         for (int i = 0; i < NP; i++) begin
            w = mx[i] < mspd;
            p = (mx[i] > b) && (w || (mx[i] - mspd) <= b);
            if (p) pc++;
            if (w) begin
               mx[i] = SW - 1;
               my[i] = gapv(int'(random), i);
            end else begin
               mx[i] = mx[i] - mspd;
            end
         end
         nc = (mcnt + pc > 255) ? 255 : mcnt + pc;
         if ((mcnt / PPL) != (nc / PPL) && mspd < MS) mspd++;
         mcnt  = nc;
         mpass = (pc > 0);
      end else begin
         mpass = 0;
      end
   endtask

   task automatic check_model();
      for (int i = 0; i < NP; i++) begin
         chk($sformatf("m_x%0d", i), 32'(lx(i)), 32'(mx[i]));
         chk($sformatf("m_y%0d", i), 32'(ly(i)), 32'(my[i]));
      end
      chk("m_pass",  32'(pass),       32'(mpass));
      chk("m_count", 32'(pass_count), 32'(mcnt));
      chk("m_speed", 32'(speed),      32'(mspd));
   endtask

   task automatic tick();
      @(posedge game_clk);
      model_step();
      #1;
      check_model();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, j, guard;

      reset = 1; restart = 0; enable = 0; random = 10'h0A5;
      bird_x = 11'd100; restart2 = 0; bird_x2 = '0;
      tick(); tick();
      // Reset values with random = 0x0A5
      chk("rst_x0", 32'(lx(0)), 319);
      chk("rst_x1", 32'(lx(1)), 639);
      chk("rst_y0", 32'(ly(0)), 200 + 'hA5);
      chk("rst_y1", 32'(ly(1)), 200 + 'h4A);
      chk("rst_speed", 32'(speed), 1);
      chk("rst_count", 32'(pass_count), 0);
      chk("rst_pass", 32'(pass), 0);

      // First crossing of bird_x=100 by pipe0 after 219 ticks
      reset = 0; enable = 1; bird_x = 11'd100;
      for (int t = 1; t <= 220; t++) begin
         random = 10'($urandom);
         tick();
         if (t == 218) chk("pass_before", 32'(pass), 0);
         if (t == 219) begin
            chk("pass_x0", 32'(lx(0)), 100);
            chk("pass_on", 32'(pass), 1);
         end
         if (t == 220) chk("pass_after", 32'(pass), 0);
      end

      // Pipe0 reaches x=0 then respawns at 639 with a fresh gap
      for (int t = 221; t <= 319; t++) begin
         random = 10'($urandom);
         tick();
      end
      chk("at_zero_x0", 32'(lx(0)), 0);
      r = int'(10'($urandom));
      random = 10'(r);
      tick();
      chk("wrap_x0", 32'(lx(0)), 639);
      chk("wrap_y0", 32'(ly(0)), 32'(gapv(r, 0)));
      chk("wrap_speed", 32'(speed), 1);

      // Randomized stimulus on the main instance; meanwhile dut2 brings
      // both of its pipes to x=0 together.
      for (int t = 0; t < 2049; t++) begin
         enable   = ($urandom_range(0, 3) != 0);
         bird_x   = XW'($urandom_range(0, SW - 1));
         random   = (t == 2048) ? 10'h0A5 : 10'($urandom);
         restart  = ($urandom_range(0, 99) == 0);
         restart2 = (t == 0);
         tick();
         if (t == 2047) begin
            chk("dual_zero_x0", 32'(px2[0 +: XW]), 0);
            chk("dual_zero_x1", 32'(px2[XW +: XW]), 0);
         end
         if (t == 2048) begin
            chk("dual_wrap_x0", 32'(px2[0 +: XW]), 639);
            chk("dual_wrap_x1", 32'(px2[XW +: XW]), 639);
            chk("dual_wrap_y0", 32'(py2[0 +: XW]), 200 + 'hA5);
            chk("dual_wrap_y1", 32'(py2[XW +: XW]), 200 + 'h4A);
            chk("dual_y_differ", 32'(py2[0 +: XW] != py2[XW +: XW]), 1);
         end
      end
      restart2 = 0;

      // Five passes raise the speed from 1 to 2
      restart = 1; enable = 1; bird_x = 11'd100;
      tick();
      restart = 0;
      guard = 0;
      while (mcnt < 5 && guard < 3000) begin
         random = 10'($urandom);
         tick();
         guard++;
      end
      chk("lvl_count", 32'(pass_count), 5);
      chk("lvl_speed", 32'(speed), 2);

      // Pipe at x=5, bird_x=4, speed 2: lands on 3 and still counts a pass
      guard = 0; j = -1;
      while (j < 0 && guard < 2000) begin
         for (int i = 0; i < NP; i++) if (mx[i] == 5 && j < 0) j = i;
         if (j < 0) begin
            random = 10'($urandom);
            tick();
            guard++;
         end
      end
      chk("fast_found", 32'(j >= 0), 1);
      if (j >= 0) begin
         chk("fast_pre_speed", 32'(speed), 2);
         bird_x = 11'd4;
         tick();
         chk("fast_x", 32'(lx(j)), 3);
         chk("fast_pass", 32'(pass), 1);
      end

      // Freeze for 50 ticks: everything holds, pass stays low
      enable = 0;
      for (int t = 0; t < 50; t++) begin
         random = 10'($urandom);
         bird_x = XW'($urandom_range(0, SW - 1));
         tick();
         chk("freeze_pass", 32'(pass), 0);
      end

      // Restart while frozen, then again mid-scroll
      restart = 1; random = 10'($urandom);
      tick();
      restart = 0;
      chk("rs_frz_x0", 32'(lx(0)), 319);
      chk("rs_frz_x1", 32'(lx(1)), 639);
      chk("rs_frz_speed", 32'(speed), 1);
      enable = 1;
      repeat (30) begin
         random = 10'($urandom);
         tick();
      end
      restart = 1;
      tick();
      restart = 0;
      chk("rs_run_x0", 32'(lx(0)), 319);
      chk("rs_run_x1", 32'(lx(1)), 639);
      chk("rs_run_speed", 32'(speed), 1);
      chk("rs_run_count", 32'(pass_count), 0);

      // Track pipe0 with the bird so it passes nearly every tick:
      // drives pass_count into saturation and speed to its ceiling.
      for (int t = 0; t < 600; t++) begin
         bird_x = XW'((mx[0] > 0) ? mx[0] - 1 : 0);
         random = 10'($urandom);
         tick();
      end
      chk("sat_count", 32'(pass_count), 255);
      chk("sat_speed", 32'(speed), MS);

      // Reset dominates restart and enable
      reset = 1; restart = 1; enable = 1; random = 10'h0A5;
      tick();
      chk("rdom_x0", 32'(lx(0)), 319);
      chk("rdom_y1", 32'(ly(1)), 200 + 'h4A);
      chk("rdom_count", 32'(pass_count), 0);
      reset = 0; restart = 0; enable = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
